// File: rtl/ahb_boot_loader_if.sv
// AHB-Lite write-port bundle between the boot loader (master) and the ITCM slave port.
interface ahb_boot_loader_if;
    logic        hsel;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [1:0]  hresp;

    modport master (
        output hsel, htrans, hsize, hwrite, haddr, hprot, hwdata,
        input  hready, hresp
    );

    modport slave (
        input  hsel, htrans, hsize, hwrite, haddr, hprot, hwdata,
        output hready, hresp
    );
endinterface

// File: rtl/ahb_boot_loader.sv
// Packs a byte stream little-endian into words and writes them to ITCM over AHB-Lite,
// holding the CPU in reset until the image has been loaded.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for start after reset
// COLLECT | accepting image bytes into the word register
// ADDR    | AHB address phase of a full-word write
// DATA    | AHB data phase, waiting for hready / ERROR
// DONE    | image loaded, CPU released
// ERR     | load aborted (bad length or slave error)
module ahb_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          AW        = 17
) (
    input  logic             sys_root_clk,
    input  logic             sys_root_rst,
    input  logic             start,
    input  logic [AW:0]      img_len,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    ahb_boot_loader_if.master ahb,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_hold
);

    typedef enum logic [2:0] {IDLE, COLLECT, ADDR, DATA, DONE, ERR} state_t;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
    localparam logic [1:0]  HT_IDLE = 2'b00;
    localparam logic [1:0]  HT_NSEQ = 2'b10;

    state_t      state;
    logic [AW:0] len_rem;
    logic [1:0]  byte_idx;
    logic [31:0] word;
    logic [31:0] addr;

    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) begin
            state      <= IDLE;
            len_rem    <= '0;
            byte_idx   <= '0;
            word       <= '0;
            addr       <= '0;
            s_ready    <= 1'b0;
            ahb.hsel   <= 1'b0;
            ahb.htrans <= HT_IDLE;
            ahb.hsize  <= 3'b010;
            ahb.hwrite <= 1'b0;
            ahb.haddr  <= '0;
            ahb.hprot  <= 4'b0011;
            ahb.hwdata <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        len_rem  <= img_len;
                        byte_idx <= '0;
                        word     <= '0;
                        addr     <= BASE_ADDR;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        // Degenerate lengths resolve immediately without touching the bus.
                        if (img_len == '0) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (img_len > MAX_LEN) begin
                            state <= ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state   <= COLLECT;
                            s_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (s_valid) begin
                        word[{byte_idx, 3'b000} +: 8] <= s_data;
                        byte_idx <= byte_idx + 2'd1;
                        len_rem  <= len_rem - ONE;
                        if (byte_idx == 2'd3 || len_rem == ONE) begin
                            state      <= ADDR;
                            byte_idx   <= '0;
                            s_ready    <= 1'b0;
                            ahb.hsel   <= 1'b1;
                            ahb.htrans <= HT_NSEQ;
                            ahb.hwrite <= 1'b1;
                            ahb.haddr  <= addr;
                        end
                    end
                end
                ADDR: begin
                    if (ahb.hready) begin
                        state      <= DATA;
                        ahb.hsel   <= 1'b0;
                        ahb.htrans <= HT_IDLE;
                        ahb.hwrite <= 1'b0;
                        ahb.hwdata <= word;
                    end
                end
                DATA: begin
                    // Abort on the first ERROR cycle so no further transfer is issued.
                    if (ahb.hresp[0]) begin
                        state <= ERR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else if (ahb.hready) begin
                        addr <= addr + 32'd4;
                        word <= '0;
                        if (len_rem != '0) begin
                            state   <= COLLECT;
                            s_ready <= 1'b1;
                        end else begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_boot_loader.sv
// Bench for ahb_boot_loader: AHB slave model with stall/error injection and a write scoreboard.
module tb_ahb_boot_loader;
    localparam int          AW   = 17;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [AW:0] img_len = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready, busy, done, error, cpu_hold;

    ahb_boot_loader_if bus();

    always #5 clk = ~clk;

    ahb_boot_loader #(.BASE_ADDR(BASE), .AW(AW)) dut (
        .sys_root_clk (clk),
        .sys_root_rst (rst),
        .start        (start),
        .img_len      (img_len),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .ahb          (bus),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cpu_hold     (cpu_hold)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         sbq[$];
    logic [31:0] mem [0:63];
    logic [7:0]  img[$];

    bit          dp_pending = 0;
    logic [31:0] dp_addr = '0;
    int          cur_word = 0, word_no = 0;
    int          stall_a = 0, stall_d = 0, err_word = -1;
    int          awaits = 0, dwaits = 0, err_ph = 0;
    int          nonseq_cycles = 0;
    logic [31:0] snap_a = '0, snap_d = '0;

    // Slave capture side: complete data phases, then register new address phases.
    always @(posedge clk) begin
        if (rst) begin
            dp_pending = 0;
            awaits = 0;
            dwaits = 0;
            err_ph = 0;
        end else begin
            if (dp_pending && bus.hready) begin
                if (!bus.hresp[0]) begin
                    mem[dp_addr[7:2]] = bus.hwdata;
                    if (sbq.size() == 0) begin
                        chk("extra_write", 32'd0, 32'd1);
                    end else begin
                        wr_t e;
                        e = sbq.pop_front();
                        chk("wr_addr", dp_addr, e.a);
                        chk("wr_data", bus.hwdata, e.d);
                    end
                end
                dp_pending = 0;
                dwaits = 0;
                err_ph = 0;
            end
            if (bus.hsel && bus.htrans == 2'b10 && bus.hready) begin
                dp_pending = 1;
                dp_addr = bus.haddr;
                cur_word = word_no;
                word_no++;
                awaits = 0;
            end
        end
    end

    // Slave response side: drive hready/hresp between edges.
    always @(negedge clk) begin
        if (rst) begin
            bus.hready = 1'b1;
            bus.hresp = 2'b00;
        end else if (dp_pending) begin
            if (dwaits < stall_d) begin
                if (dwaits > 0) chk("hwdata_stable", bus.hwdata, snap_d);
                else snap_d = bus.hwdata;
                bus.hready = 1'b0;
                bus.hresp = 2'b00;
                dwaits++;
            end else if (cur_word == err_word) begin
                bus.hresp = 2'b01;
                bus.hready = (err_ph != 0);
                err_ph = 1;
            end else begin
                bus.hready = 1'b1;
                bus.hresp = 2'b00;
            end
        end else if (bus.hsel && bus.htrans == 2'b10) begin
            nonseq_cycles++;
            bus.hresp = 2'b00;
            if (awaits < stall_a) begin
                if (awaits > 0) begin
                    chk("haddr_stable", bus.haddr, snap_a);
                    chk("htrans_stable", {30'd0, bus.htrans}, 32'd2);
                end else begin
                    snap_a = bus.haddr;
                end
                bus.hready = 1'b0;
                awaits++;
            end else begin
                bus.hready = 1'b1;
            end
        end else begin
            bus.hready = 1'b1;
            bus.hresp = 2'b00;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BEEF;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"},  {31'd0, s_ready},     32'd0);
        chk({tag, "_hsel"},     {31'd0, bus.hsel},    32'd0);
        chk({tag, "_htrans"},   {30'd0, bus.htrans},  32'd0);
        chk({tag, "_hsize"},    {29'd0, bus.hsize},   32'd2);
        chk({tag, "_hwrite"},   {31'd0, bus.hwrite},  32'd0);
        chk({tag, "_haddr"},    bus.haddr,            32'd0);
        chk({tag, "_hprot"},    {28'd0, bus.hprot},   32'd3);
        chk({tag, "_hwdata"},   bus.hwdata,           32'd0);
        chk({tag, "_flags"},    {28'd0, busy, done, error, cpu_hold}, 32'b0001);
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data = b;
        for (int n = 0; n < 100; n++) begin
            if (error) return;
            if (s_ready) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start(input int len);
        img_len = (AW+1)'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs a full load of img[0 +: len]; scoreboard gets every word expected to complete OK.
    task automatic load(input int len, input int ewrd);
        int nw;
        nw = (len + 3) / 4;
        word_no = 0;
        err_word = ewrd;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] d;
            d = '0;
            for (int b = 0; b < 4; b++)
                if (4*w + b < len) d[8*b +: 8] = img[4*w + b];
            if (ewrd < 0 || w < ewrd) sbq.push_back('{BASE + 32'(4*w), d});
        end
        pulse_start(len);
        for (int i = 0; i < len; i++) begin
            if (error) break;
            send_byte(img[i]);
        end
        s_valid = 1'b0;
        begin
            int n;
            for (n = 0; n < 200; n++) begin
                if (done || error) break;
                @(negedge clk);
            end
            if (n == 200) chk("load_timeout", 32'd0, 32'd1);
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        sbq.delete();
        err_word = -1;
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // 8-byte image, continuous stream.
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load(8, -1);
        chk("t1_done", {29'd0, busy, done, cpu_hold}, 32'b010);
        chk("t1_mem0", mem[0], 32'h0403_0201);
        chk("t1_mem1", mem[1], 32'h0807_0605);

        // Partial final word, exactly two transfers.
        clear_mem();
        nonseq_cycles = 0;
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load(5, -1);
        chk("t2_nonseq", nonseq_cycles, 32'd2);
        chk("t2_mem0", mem[0], 32'hDDCC_BBAA);
        chk("t2_mem1", mem[1], 32'h0000_00EE);
        chk("t2_done", {31'd0, done}, 32'd1);

        // Three wait states in both address and data phases.
        clear_mem();
        stall_a = 3;
        stall_d = 3;
        img.delete();
        for (int i = 0; i < 8; i++) img.push_back(8'($urandom_range(0, 255)));
        load(8, -1);
        stall_a = 0;
        stall_d = 0;
        chk("t3_mem0", mem[0], {img[3], img[2], img[1], img[0]});
        chk("t3_mem1", mem[1], {img[7], img[6], img[5], img[4]});
        chk("t3_done", {31'd0, done}, 32'd1);

        // ERROR response on the second word aborts the load.
        clear_mem();
        nonseq_cycles = 0;
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        load(12, 1);
        chk("t4_flags", {29'd0, done, error, cpu_hold}, 32'b011);
        chk("t4_nonseq", nonseq_cycles, 32'd2);
        chk("t4_mem0", mem[0], 32'h4433_2211);
        chk("t4_mem1", mem[1], 32'hDEAD_BEEF);
        img = '{8'hC0, 8'hFF, 8'hEE, 8'h15};
        load(4, -1);
        chk("t4_retry_flags", {29'd0, done, error, cpu_hold}, 32'b100);
        chk("t4_retry_mem0", mem[0], 32'h15EE_FFC0);

        // Oversized image is rejected without bus traffic.
        nonseq_cycles = 0;
        pulse_start((1 << AW) + 1);
        chk("t5_big_flags", {28'd0, busy, done, error, cpu_hold}, 32'b0011);
        repeat (4) @(negedge clk);
        chk("t5_big_nonseq", nonseq_cycles, 32'd0);

        // Zero-length image finishes on the next cycle.
        pulse_start(0);
        chk("t5_zero_flags", {28'd0, busy, done, error, cpu_hold}, 32'b0100);
        repeat (4) @(negedge clk);
        chk("t5_zero_nonseq", nonseq_cycles, 32'd0);

        // Reset after two bytes of a load, then a clean reload.
        clear_mem();
        word_no = 0;
        pulse_start(8);
        send_byte(8'h5A);
        send_byte(8'hA5);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("t6");
        @(negedge clk);
        img = '{8'h21, 8'h43, 8'h65, 8'h87};
        load(4, -1);
        chk("t6_mem0", mem[0], 32'h8765_4321);
        chk("t6_done", {31'd0, done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
        $fatal(1);
    end
endmodule

// File: doc/ahb_boot_loader.md
Name: ahb_boot_loader

Overview:
- AHB-Lite single-master write engine that sits directly upstream of the ITCM slave port of sram_top.
- Receives a boot image as a byte stream from the UART/debug receiver and packs the bytes little-endian into 32-bit words.
- Writes the words sequentially into ITCM starting at BASE_ADDR.
- Holds the CPU in reset (cpu_hold) until the image is loaded, so ITCM contents need not come from a memory init file.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word aligned.
- AW, 17, ITCM byte-address width (17 = 128k, 15 = 32k); the image must fit in 2^AW bytes.

Ports:
- sys_root_clk  in  1  system clock
- sys_root_rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR
- img_len  in  AW+1  image length in bytes; sampled on start
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_ready  out  1  byte accepted when s_valid && s_ready
- hsel  out  1  to hsel_itcm
- htrans  out  2  to htrans_itcm
- hsize  out  3  to hsize_itcm
- hwrite  out  1  to hwrite_itcm
- haddr  out  32  to haddr_itcm
- hprot  out  4  to hprot_itcm
- hwdata  out  32  to hwdata_itcm
- hready  in  1  from hreadyout_itcm; at top level hready_itcm is tied to this same signal
- hresp  in  2  from hresp_itcm; bit 0 = ERROR
- busy  out  1  load in progress
- done  out  1  load completed OK; sticky
- error  out  1  load aborted; sticky
- cpu_hold  out  1  CPU reset request

Behaviour:
- Reset values:
  - States: state=IDLE.
  - Outputs: s_ready=0, hsel=0, htrans=2'b00, hsize=3'b010, hwrite=0, haddr=0, hprot=4'b0011, hwdata=0, busy=0, done=0, error=0, cpu_hold=1.
  - Internal: word/byte counters=0.
- Reset mid-load: everything returns to the reset values next edge. Any in-flight AHB transfer is abandoned; the slave shares the same reset.
- FSM states: IDLE, COLLECT, ADDR, DATA, DONE, ERR. All outputs are registered from state and datapath.
- IDLE/DONE/ERR + start:
  - Latch img_len; clear done/error; set busy=1, cpu_hold=1; addr=BASE_ADDR; byte_idx=0.
  - img_len==0 -> DONE next cycle, with no AHB traffic.
  - img_len > 2^AW -> ERR next cycle, with no AHB traffic.
  - Otherwise -> COLLECT.
- COLLECT:
  - s_ready=1. Each accepted byte goes into word lane byte_idx (byte 0 -> bits 7:0), and byte_idx increments.
  - A word is complete when byte_idx reaches 3 or the last image byte is accepted. Unfilled lanes of a final partial word are 0x00. The word is always written full-size.
  - Word complete -> ADDR next cycle; s_ready=0 from that cycle.
- ADDR (address phase):
  - hsel=1, htrans=NONSEQ 2'b10, hwrite=1, hsize=3'b010, haddr=addr.
  - hready=0: hold all address-phase signals unchanged.
  - hready=1: -> DATA.
- DATA (data phase):
  - hsel=0, htrans=IDLE; hwdata=word, held stable until hready=1.
  - hready=1 with hresp[0]=0: addr+=4, clear the word register.
    - Bytes remaining -> COLLECT.
    - Otherwise -> DONE.
  - hresp[0]=1 (first or second cycle of the ERROR response) -> ERR; no further transfers.
- DONE: busy=0, done=1, cpu_hold=0.
- ERR: busy=0, error=1, cpu_hold=1.
- Throughput: at least 6 cycles per word with a zero-wait slave (4 byte cycles + ADDR + DATA).
- Byte count bookkeeping: a remaining-bytes counter of AW+1 bits, decremented per accepted byte. Completion is defined by this counter reaching 0.
- haddr increments by 4 per word with no wrap. Bounded by the img_len check, so the top word is BASE_ADDR+2^AW-4.
- A start pulse during COLLECT, ADDR or DATA is ignored.
- s_valid while s_ready=0 is not consumed; the source must hold the byte.

Test Plan:
- Reset, then img_len=8, bytes 01..08 with s_valid always high -> two writes: haddr 0x0 hwdata 0x04030201, haddr 0x4 hwdata 0x08070605. Then done=1, cpu_hold=0, busy=0; ITCM readback matches.
- img_len=5, bytes AA BB CC DD EE -> writes 0xDDCCBBAA@0x0 and 0x000000EE@0x4; exactly 2 NONSEQ cycles seen.
- Slave stalls hready=0 for 3 cycles in both ADDR and DATA -> haddr/htrans/hwdata stable throughout; final memory correct.
- hresp=2'b01 injected on the 2nd word data phase -> error=1, cpu_hold=1, no 3rd NONSEQ. A new start with img_len=4 clears error and succeeds.
- img_len=0 -> done=1 one cycle after start, htrans never NONSEQ. img_len=2^AW+1 -> error=1, no AHB traffic.
- sys_root_rst asserted for 1 cycle mid-COLLECT after 2 bytes -> next cycle all outputs at reset values and s_ready=0. A following load at BASE_ADDR writes correctly with no stale bytes.
